// File: rtl/clkdiv_pkg.sv
// Shared constants for the clock-divider run controller:
// FSM state encodings and tick counter width/saturation value.
package clkdiv_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    localparam int          TICK_W   = 16;
    localparam logic [15:0] TICK_SAT = 16'hFFFF;

endpackage

// File: rtl/clkdiv_counter.sv
// Period counter: counts 0..tc then wraps; held at zero while cleared.
// wrap flags the last cycle of each period.
module clkdiv_counter #(
    parameter int N = 26
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [N-1:0] tc,
    output logic [N-1:0] cnt,
    output logic         wrap
);

    assign wrap = (cnt == tc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + N'(1);
        end
    end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Run control and period-boundary reconfiguration for the clock divider.
// Define CLKDIV_TICKCNT_EN to add the saturating tick_cnt output.
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int          N = 26,
    parameter int unsigned M = 12500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              cfg_valid,
    input  logic [N-1:0]      cfg_tc,
    output logic              cfg_ready,
    output logic              tick,
    output logic              q,
    output logic              busy
`ifdef CLKDIV_TICKCNT_EN
    ,
    output logic [TICK_W-1:0] tick_cnt
`endif
);

    localparam logic [N-1:0] M_TC = N'(M);

    logic [1:0]   state;
    logic [1:0]   state_nxt;
    logic [N-1:0] cnt;
    logic [N-1:0] tc_act;
    logic [N-1:0] tc_pend;
    logic         pend;
    logic         wrap;
    logic         running;
    logic         xfer;
    logic [N-1:0] tce;

    assign running = (state != ST_IDLE);

    clkdiv_counter #(.N(N)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (!running),
        .en    (running),
        .tc    (tc_act),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    assign tick      = running && wrap;
    assign q         = running && (cnt >= (tc_act >> 1));
    assign busy      = running;
    assign cfg_ready = !pend;
    assign xfer      = cfg_valid && !pend;
    assign tce       = (cfg_tc == '0) ? N'(1) : cfg_tc;

    // A fresh start in STOPPING cancels the stop even on the wrap cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start && !stop) state_nxt = ST_RUN;
            ST_RUN:  if (stop) state_nxt = ST_STOP;
            ST_STOP: begin
                if (start && !stop) state_nxt = ST_RUN;
                else if (wrap)      state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // xfer needs !pend, so the apply and capture branches never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tc_act  <= M_TC;
            tc_pend <= '0;
            pend    <= 1'b0;
        end else begin
            if (xfer && !running) begin
                tc_act <= tce;
            end
            if (xfer && running) begin
                tc_pend <= tce;
                pend    <= 1'b1;
            end
            if (tick && pend) begin
                tc_act <= tc_pend;
                pend   <= 1'b0;
            end
        end
    end

`ifdef CLKDIV_TICKCNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (!running && state_nxt == ST_RUN) begin
            tick_cnt <= '0;
        end else if (tick && tick_cnt != TICK_SAT) begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end
`endif

endmodule
